// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command path: FSM state codes,
// completion codes, well-known command/response bytes and small helpers
// used to turn microsecond timings into clock-cycle loads.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_RTS       = 3'd2;
  localparam state_t ST_SHIFT     = 3'd3;
  localparam state_t ST_LACK      = 3'd4;
  localparam state_t ST_WAIT_IDLE = 3'd5;
  localparam state_t ST_RESP      = 3'd6;
  localparam state_t ST_FIN       = 3'd7;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_LINE  = 2'd2;
  localparam logic [1:0] ERR_RESP  = 2'd3;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  // Cycles for a duration in microseconds; 64-bit math avoids overflow.
  function automatic int us_to_cyc(input int clk_hz, input int us);
    longint t;
    t = (longint'(clk_hz) * longint'(us)) / longint'(1_000_000);
    return int'(t);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchroniser for the raw PS/2 clock and data lines plus a
// one-cycle strobe on each falling edge of the clock line. Flops reset to 1
// (idle bus level) so reset release never produces a false edge.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_line,
  input  logic data_line,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  // [0] = sync0 (metastable stage), [1] = sync1, [2] = sync2
  logic [2:0] clk_sr;
  logic [2:0] data_sr;

  // Shift both raw lines through their synchroniser chains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr  <= 3'b111;
      data_sr <= 3'b111;
    end else begin
      clk_sr  <= {clk_sr[1:0], clk_line};
      data_sr <= {data_sr[1:0], data_line};
    end
  end

  // Level outputs come from the last stage; data therefore trails the clock
  // strobe by one cycle, well inside the device's data setup time.
  assign clk_sync  = clk_sr[2];
  assign data_sync = data_sr[2];
  assign clk_fall  = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibits the bus, issues
// request-to-send, shifts one command byte out on device clock edges, checks
// the line ACK and then the device response byte from the receiver.
// Optional feature macro: PS2_CMD_RETRY_EN (resend on 8'hFE up to MAX_RETRY).
// Command handshake: a byte transfers on a clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so cmd_valid held
// while busy has no effect.
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int START_TO_US = 15_000,
  parameter int BIT_TO_US   = 2_000,
  parameter int RESP_TO_US  = 20_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_hold,
  output logic       done,
  output logic [1:0] err_code
);

  localparam int INH_CYC   = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int START_CYC = us_to_cyc(CLK_HZ, START_TO_US);
  localparam int BIT_CYC   = us_to_cyc(CLK_HZ, BIT_TO_US);
  localparam int RESP_CYC  = us_to_cyc(CLK_HZ, RESP_TO_US);
  localparam int MAX_LOAD  = max4(INH_CYC, START_CYC, BIT_CYC, RESP_CYC);
  localparam int TW        = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
  localparam int RW        = $clog2(MAX_RETRY + 2);

  // Timer loads are "cycles - 1": expiry is detected when the count is zero.
  localparam logic [TW-1:0] INH_LD   = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] START_LD = TW'(START_CYC - 1);
  localparam logic [TW-1:0] BIT_LD   = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] RESP_LD  = TW'(RESP_CYC - 1);

`ifdef PS2_CMD_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic          clk_sync;
  logic          data_sync;
  logic          clk_fall;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    bit_cnt_q;
  logic [8:0]    shreg_q;   // {parity, byte}, shifted out LSB first
  logic [7:0]    byte_q;    // kept for resend
  logic [RW-1:0] retry_q;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic [1:0]    err_q;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_line  (ps2_clk_i),
    .data_line (ps2_data_i),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // Command sequencer FSM with its shared timeout down-counter and line drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      byte_q    <= '0;
      retry_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      if (timer_q != '0) timer_q <= timer_q - TW'(1);
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            byte_q    <= cmd_data;
            shreg_q   <= {~^cmd_data, cmd_data};
            retry_q   <= '0;
            err_q     <= ERR_OK;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            timer_q   <= INH_LD;
            state_q   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (timer_q == '0) begin
            data_oe_q <= 1'b1;       // start bit; clock released one cycle later
            timer_q   <= START_LD;
            state_q   <= ST_RTS;
          end
        end
        ST_RTS: begin
          clk_oe_q <= 1'b0;
          if (clk_fall) begin
            data_oe_q <= ~shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[8:1]};
            bit_cnt_q <= 4'd1;
            timer_q   <= BIT_LD;
            state_q   <= ST_SHIFT;
          end else if (timer_q == '0) begin
            data_oe_q <= 1'b0;
            err_q     <= ERR_START;
            state_q   <= ST_FIN;
          end
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            timer_q   <= BIT_LD;
            if (bit_cnt_q == 4'd9) begin
              data_oe_q <= 1'b0;     // fall 10: stop bit, line released
              state_q   <= ST_LACK;
            end else begin
              data_oe_q <= ~shreg_q[0];
              shreg_q   <= {1'b0, shreg_q[8:1]};
            end
          end else if (timer_q == '0) begin
            data_oe_q <= 1'b0;
            err_q     <= ERR_LINE;
            state_q   <= ST_FIN;
          end
        end
        ST_LACK: begin
          if (clk_fall) begin
            if (!data_sync) begin
              state_q <= ST_WAIT_IDLE;
            end else begin
              err_q   <= ERR_LINE;
              state_q <= ST_FIN;
            end
          end else if (timer_q == '0) begin
            err_q   <= ERR_LINE;
            state_q <= ST_FIN;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            timer_q <= RESP_LD;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rx_valid) begin
            if (rx_byte == RSP_ACK) begin
              err_q   <= ERR_OK;
              state_q <= ST_FIN;
            end else if (RETRY_EN && (rx_byte == RSP_RESEND) &&
                         (retry_q < RW'(MAX_RETRY))) begin
              retry_q   <= retry_q + RW'(1);
              shreg_q   <= {~^byte_q, byte_q};
              clk_oe_q  <= 1'b1;
              data_oe_q <= 1'b0;
              timer_q   <= INH_LD;
              state_q   <= ST_INHIBIT;
            end else begin
              err_q   <= ERR_RESP;
              state_q <= ST_FIN;
            end
          end else if (timer_q == '0) begin
            err_q   <= ERR_RESP;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign err_code    = err_q;
  assign rx_hold     = (state_q == ST_INHIBIT) || (state_q == ST_RTS) ||
                       (state_q == ST_SHIFT)   || (state_q == ST_LACK) ||
                       (state_q == ST_WAIT_IDLE);

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: a PS/2 device model on open-drain lines, a frame
// scoreboard (expected host frames queued at command time, popped when the
// device model has clocked a frame in) and a table of command scenarios.
// Timing is scaled to a 1 MHz clock so every microsecond is one cycle.
module tb_ps2_cmd_ctrl;
  import ps2_pkg::*;

  localparam int CLK_HZ      = 1_000_000;
  localparam int INHIBIT_US  = 100;
  localparam int START_TO_US = 1_500;
  localparam int BIT_TO_US   = 200;
  localparam int RESP_TO_US  = 2_000;
  localparam int MAX_RETRY   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_hold, done;
  logic [1:0] err_code;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain bus: a line is low if either side pulls it.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_cmd_ctrl #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .START_TO_US(START_TO_US),
    .BIT_TO_US(BIT_TO_US), .RESP_TO_US(RESP_TO_US), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_hold(rx_hold),
    .done(done), .err_code(err_code)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int oe_run = 0;
  int oe_run_max = 0;
  int hold_bad = 0;
  int rts_cyc = 0;
  int fall_cyc = 0;

  logic [10:0] exp_q[$];
  logic [1:0]  done_err_q[$];
  logic [1:0]  done_oe_q[$];
  int          done_cyc_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && cmd_valid && cmd_ready) hs_cnt = hs_cnt + 1;
  end

  always @(negedge clk) begin
    if (done) begin
      done_err_q.push_back(err_code);
      done_oe_q.push_back({ps2_clk_oe, ps2_data_oe});
      done_cyc_q.push_back(cyc);
    end
    if (ps2_clk_oe) oe_run = oe_run + 1;
    else oe_run = 0;
    if (oe_run > oe_run_max) oe_run_max = oe_run;
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total = total + 1;
    if (act < lo || act > hi) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic check_frame(input logic [10:0] got);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL frame: got %0h with no frame expected", got);
    end else begin
      e = exp_q.pop_front();
      check("frame", got, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Device model: wait for request-to-send, then generate n_falls clock
  // pulses, sampling host data just before each rising edge. On pulse 11 it
  // optionally pulls data low as the line ACK.
  task automatic bfm_xfer(input int n_falls, input bit ack_low, input int rx_at,
                          input int bound, output logic [10:0] got, output bit seen);
    int t;
    t = 0;
    got = '0;
    seen = 1'b0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (t < bound) begin
      seen = 1'b1;
      rts_cyc = cyc;
      repeat (20) @(negedge clk);
      got[0] = ps2_data_i;
      for (int i = 1; i <= n_falls; i++) begin
        if (i == 11 && ack_low) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        fall_cyc = cyc;
        repeat (10) @(negedge clk);
        if (i <= 10) got[i] = ps2_data_i;
        if ((i < 11 || ack_low) && !rx_hold) hold_bad++;
        if (i == rx_at) begin
          rx_byte  = RSP_ACK;
          rx_valid = 1'b1;
          @(negedge clk);
          rx_valid = 1'b0;
        end
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        if (i == 11) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic send_resp(input logic [7:0] b);
    int t;
    t = 0;
    while (rx_hold && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("resp_window_open", (t < 500), 1);
    repeat (5) @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output logic [1:0] err,
                           output logic [1:0] oes, output int dcyc, output bit seen);
    int t;
    t = 0;
    err = 2'b00;
    oes = 2'b11;
    dcyc = 0;
    seen = 1'b0;
    while (done_err_q.size() == 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (done_err_q.size() != 0) begin
      seen = 1'b1;
      err  = done_err_q.pop_front();
      oes  = done_oe_q.pop_front();
      dcyc = done_cyc_q.pop_front();
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] cmd;
    bit         ack_low;
    bit         send_rsp;
    logic [7:0] rsp;
    logic [1:0] exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [10:0] got;
  bit          seen, dseen;
  logic [1:0]  err, oes;
  int          dcyc, t;

  initial begin
    vecs[0] = '{8'hED, 1'b1, 1'b1, 8'hFA, ERR_OK};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFA, ERR_OK};
    vecs[2] = '{8'hF4, 1'b1, 1'b1, 8'hAA, ERR_RESP};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 8'h00, ERR_LINE};
    vecs[4] = '{8'hA5, 1'b1, 1'b0, 8'h00, ERR_RESP};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h12, ERR_RESP};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rx_hold", rx_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table of complete transfers
    for (int i = 0; i < 6; i++) begin
      oe_run_max = 0;
      send_cmd(vecs[i].cmd);
      exp_q.push_back(frame_of(vecs[i].cmd));
      bfm_xfer(11, vecs[i].ack_low, 0, 1000, got, seen);
      check("rts_seen", seen, 1);
      check_frame(got);
      check_rng("inhibit_len", oe_run_max, INHIBIT_US, INHIBIT_US + 3);
      if (vecs[i].send_rsp) send_resp(vecs[i].rsp);
      wait_done(RESP_TO_US + 1000, err, oes, dcyc, dseen);
      check("done_seen", dseen, 1);
      check("err_code", err, vecs[i].exp_err);
      check("lines_at_done", oes, 0);
      if (!vecs[i].ack_low) check_rng("nack_latency", dcyc - fall_cyc, 0, 20);
      @(negedge clk);
      check("ready_after", cmd_ready, 1);
    end

    // Device never clocks: start timeout
    send_cmd(CMD_SET_LED);
    bfm_xfer(0, 1'b0, 0, 1000, got, seen);
    check("to_rts_seen", seen, 1);
    check("to_start_bit", got[0], 0);
    wait_done(START_TO_US + 500, err, oes, dcyc, dseen);
    check("to_done_seen", dseen, 1);
    check("to_err", err, ERR_START);
    check("to_lines", oes, 0);
    check_rng("to_time", dcyc - rts_cyc, START_TO_US - 3, START_TO_US + 1);

    // Resend request from the device
    send_cmd(CMD_RESET);
    exp_q.push_back(frame_of(CMD_RESET));
    bfm_xfer(11, 1'b1, 0, 1000, got, seen);
    check_frame(got);
    send_resp(RSP_RESEND);
`ifdef PS2_CMD_RETRY_EN
    exp_q.push_back(frame_of(CMD_RESET));
    bfm_xfer(11, 1'b1, 0, 1000, got, seen);
    check("resend_seen", seen, 1);
    check_frame(got);
    send_resp(RSP_ACK);
    wait_done(3000, err, oes, dcyc, dseen);
    check("fe_err", err, ERR_OK);
`else
    wait_done(3000, err, oes, dcyc, dseen);
    check("fe_err", err, ERR_RESP);
`endif
    check("fe_done_seen", dseen, 1);
    bfm_xfer(0, 1'b0, 0, 300, got, seen);
    check("fe_no_extra_xfer", seen, 0);

    // Reset in the middle of the shift phase (after fall 4, data bit 3 = 0)
    send_cmd(8'hE3);
    bfm_xfer(4, 1'b1, 0, 1000, got, seen);
    check("mid_data_oe", ps2_data_oe, 1);
    check("mid_rx_hold", rx_hold, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_clk_oe", ps2_clk_oe, 0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_rx_hold", rx_hold, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_err_q.size(), 0);

    // cmd_valid held while busy, stray rx_valid during shift
    hs_cnt = 0;
    hold_bad = 0;
    @(negedge clk);
    cmd_data  = 8'h55;
    cmd_valid = 1'b1;
    exp_q.push_back(frame_of(8'h55));
    bfm_xfer(11, 1'b1, 5, 1000, got, seen);
    check_frame(got);
    check("hold_through_xfer", hold_bad, 0);
    send_resp(RSP_ACK);
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    wait_done(100, err, oes, dcyc, dseen);
    check("busy_done_seen", dseen, 1);
    check("busy_err", err, ERR_OK);
    bfm_xfer(0, 1'b0, 0, 300, got, seen);
    check("busy_no_extra_xfer", seen, 0);
    check("busy_handshakes", hs_cnt, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: keeps the run bounded even if a wait above misbehaves.
  initial begin
    #900_000;
    bad = bad + 1;
    $display("FAIL watchdog: time %0t reached, limit 900000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
